// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-divide step per cycle.
// Freezes the upstream pipeline while busy; divide-by-zero and signed overflow bypass the iteration.
module muldiv_seq #(
  parameter int D_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [2:0]         op_i,
  input  logic [D_WIDTH-1:0] src_a_i,
  input  logic [D_WIDTH-1:0] src_b_i,
  input  logic               flush_i,
  output logic               stall_o,
  output logic               busy_o,
  output logic               valid_o,
  output logic [D_WIDTH-1:0] result_o
);

  localparam int W  = D_WIDTH;
  localparam int CW = $clog2(D_WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state, state_nxt;
  logic [2:0]       op_q;
  logic             neg_q;
  logic [2*W-1:0]   acc;
  logic [W-1:0]     opnd_q;
  logic [CW-1:0]    count;
  logic [W-1:0]     result_q;

  // Operand preparation for the accept cycle
  logic             sign_a_en, sign_b_en, neg_a, neg_b, neg_res;
  logic [W-1:0]     a_abs, b_abs;
  logic             b_zero, ovf, special;
  logic [W-1:0]     special_res;
  logic             accept;

  always_comb begin
    sign_a_en = (op_i == 3'b001) || (op_i == 3'b010) || (op_i == 3'b100) || (op_i == 3'b110);
    sign_b_en = (op_i == 3'b001) || (op_i == 3'b100) || (op_i == 3'b110);
    neg_a     = sign_a_en & src_a_i[W-1];
    neg_b     = sign_b_en & src_b_i[W-1];
    a_abs     = neg_a ? -src_a_i : src_a_i;
    b_abs     = neg_b ? -src_b_i : src_b_i;
    // Remainder follows the dividend; everything else follows the product of signs.
    neg_res   = (op_i[2] && op_i[1]) ? neg_a : (neg_a ^ neg_b);
    b_zero    = (src_b_i == '0);
    ovf       = ~op_i[0] && (src_a_i == {1'b1, {(W-1){1'b0}}}) && (src_b_i == '1);
    special   = op_i[2] && (b_zero || ovf);
    if (b_zero)
      special_res = op_i[1] ? src_a_i : '1;
    else
      special_res = op_i[1] ? '0 : src_a_i;
    accept    = (state == IDLE) && start_i && !flush_i;
  end

  // One iteration step
  logic [W:0]       mul_sum, div_trial;
  logic [2*W-1:0]   acc_nxt;

  always_comb begin
    mul_sum   = {1'b0, acc[2*W-1:W]} + {1'b0, (acc[0] ? opnd_q : {W{1'b0}})};
    div_trial = acc[2*W-1:W-1] - {1'b0, opnd_q};
    if (!op_q[2])
      acc_nxt = {mul_sum, acc[W-1:1]};
    else if (div_trial[W])
      acc_nxt = {acc[2*W-2:0], 1'b0};
    else
      acc_nxt = {div_trial[W-1:0], acc[W-2:0], 1'b1};
  end

  // Sign fix-up and half/quotient/remainder selection
  logic [2*W-1:0]   prod;
  logic [W-1:0]     div_sel, fix_res;

  always_comb begin
    prod    = neg_q ? -acc : acc;
    div_sel = op_q[1] ? acc[2*W-1:W] : acc[W-1:0];
    if (!op_q[2])
      fix_res = (op_q == 3'b000) ? prod[W-1:0] : prod[2*W-1:W];
    else
      fix_res = neg_q ? -div_sel : div_sel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = special ? DONE : CALC;
      CALC: if (count == CW'(D_WIDTH - 1)) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush_i && state != IDLE)
      state_nxt = IDLE;
  end

  always_comb begin
    busy_o   = (state != IDLE);
    stall_o  = accept || (((state == CALC) || (state == FIX)) && !flush_i);
    valid_o  = (state == DONE) && !flush_i;
    result_o = result_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      neg_q    <= 1'b0;
      acc      <= '0;
      opnd_q   <= '0;
      count    <= '0;
      result_q <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_q  <= op_i;
          neg_q <= neg_res;
          count <= '0;
          if (special) begin
            result_q <= special_res;
          end else begin
            // Multiplier or dividend starts in the low half; the other operand stays fixed.
            acc    <= {{W{1'b0}}, op_i[2] ? a_abs : b_abs};
            opnd_q <= op_i[2] ? b_abs : a_abs;
          end
        end
        CALC: begin
          acc   <= acc_nxt;
          count <= count + 1'b1;
        end
        FIX: if (!flush_i) result_q <= fix_res;
        default: ;
      endcase
    end
  end

endmodule
